freq_meas_scheduler: RTL and testbench



---
 rtl/freq_meas_scheduler.sv | 173 +++++++++++++++++
 tb/tb_freq_meas_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meas_scheduler.sv
// Sequencer for one shared gated pulse counter serving four channels:
// round-robin select, clear, timed gate, latch+scale to Hz, valid/ready output.
module freq_meas_scheduler #(
    parameter int CLK_FREQ = 20_000_000,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cont_mode,
    input  logic [3:0]       ch_en,
    input  logic [1:0]       gate_sel,
    output logic [1:0]       ch_sel,
    output logic             cnt_clr,
    output logic             cnt_en,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_ch,
    output logic [CNT_W-1:0] res_freq,
    output logic             res_ovf,
    output logic             busy
);

    localparam int PW = CNT_W + 10;

    localparam logic [31:0] G0 = 32'(CLK_FREQ);
    localparam logic [31:0] G1 = 32'(CLK_FREQ / 10);
    localparam logic [31:0] G2 = 32'(CLK_FREQ / 100);
    localparam logic [31:0] G3 = 32'(CLK_FREQ / 1000);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CLEAR,
        S_GATE,
        S_LATCH,
        S_OUTPUT
    } state_t;

    state_t      state;
    logic [1:0]  last_ch;
    logic [3:0]  sweep_mask;
    logic [1:0]  gate_r;
    logic [31:0] gate_cnt;

    logic [3:0]  cand;
    logic [2:0]  pick;
    logic [31:0] gate_last;
    logic [9:0]  mult;
    logic [PW-1:0] prod;
    logic        ovf;

    // {found, index}: first set bit of m after position last, wrapping mod 4
    function automatic logic [2:0] rr_pick(input logic [1:0] last,
                                           input logic [3:0] m);
        logic [2:0] r;
        logic [1:0] idx;
        r = '0;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (m[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    assign cand = sweep_mask & ch_en;
    assign pick = rr_pick(last_ch, cand);

    always_comb begin
        gate_last = G0 - 32'd1;
        mult      = 10'd1;
        unique case (gate_r)
            2'd0: begin gate_last = G0 - 32'd1; mult = 10'd1;    end
            2'd1: begin gate_last = G1 - 32'd1; mult = 10'd10;   end
            2'd2: begin gate_last = G2 - 32'd1; mult = 10'd100;  end
            2'd3: begin gate_last = G3 - 32'd1; mult = 10'd1000; end
            default: ;
        endcase
    end

    assign prod = PW'(cnt_value) * PW'(mult);
    assign ovf  = |prod[PW-1:CNT_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_ch    <= 2'd3;
            sweep_mask <= '0;
            gate_r     <= '0;
            gate_cnt   <= '0;
            ch_sel     <= '0;
            cnt_clr    <= 1'b0;
            cnt_en     <= 1'b0;
            res_valid  <= 1'b0;
            res_ch     <= '0;
            res_freq   <= '0;
            res_ovf    <= 1'b0;
            busy       <= 1'b0;
        end else if (abort) begin
            state      <= S_IDLE;
            sweep_mask <= '0;
            cnt_clr    <= 1'b0;
            cnt_en     <= 1'b0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && |ch_en) begin
                        sweep_mask <= ch_en;
                        state      <= S_SELECT;
                        busy       <= 1'b1;
                    end
                end
                S_SELECT: begin
                    if (pick[2]) begin
                        ch_sel  <= pick[1:0];
                        last_ch <= pick[1:0];
                        gate_r  <= gate_sel;
                        cnt_clr <= 1'b1;
                        state   <= S_CLEAR;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    cnt_clr  <= 1'b0;
                    cnt_en   <= 1'b1;
                    gate_cnt <= '0;
                    state    <= S_GATE;
                end
                S_GATE: begin
                    if (gate_cnt == gate_last) begin
                        cnt_en <= 1'b0;
                        state  <= S_LATCH;
                    end else begin
                        gate_cnt <= gate_cnt + 32'd1;
                    end
                end
                S_LATCH: begin
                    res_ch     <= ch_sel;
                    res_freq   <= ovf ? '1 : prod[CNT_W-1:0];
                    res_ovf    <= ovf;
                    res_valid  <= 1'b1;
                    sweep_mask[ch_sel] <= 1'b0;
                    state      <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (|cand) begin
                            state <= S_SELECT;
                        end else if (cont_mode && |ch_en) begin
                            sweep_mask <= ch_en;
                            state      <= S_SELECT;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meas_scheduler.sv
// Bench for freq_meas_scheduler: table vectors, random sweeps vs a
// round-robin reference model, and hand sequences for stall/abort/reset.
module tb_freq_meas_scheduler;

    localparam int CLK_FREQ = 1000;
    localparam int CNT_W    = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             cont_mode;
    logic [3:0]       ch_en;
    logic [1:0]       gate_sel;
    logic [1:0]       ch_sel;
    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_value;
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_ch;
    logic [CNT_W-1:0] res_freq;
    logic             res_ovf;
    logic             busy;

    freq_meas_scheduler #(.CLK_FREQ(CLK_FREQ), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cont_mode(cont_mode), .ch_en(ch_en), .gate_sel(gate_sel),
        .ch_sel(ch_sel), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
        .cnt_value(cnt_value), .res_valid(res_valid),
        .res_ready(res_ready), .res_ch(res_ch), .res_freq(res_freq),
        .res_ovf(res_ovf), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // shared pulse counter: either counts 'rate' per gated cycle or is forced
    logic [31:0] cnt;
    logic [31:0] rate;
    logic [31:0] fixed_val;
    bit          use_fixed;

    always @(posedge clk) begin
        if (cnt_clr) cnt <= 32'd0;
        else if (cnt_en) cnt <= cnt + rate;
    end
    assign cnt_value = use_fixed ? fixed_val : cnt;

    int checks = 0;
    int errors = 0;
    int cur_g;
    bit gate_chk;
    int clr_cyc;
    int v_cyc;
    int model_last;

    int          exp_ch[$];
    logic [31:0] exp_f[$];
    bit          exp_o[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // gate length and channel stability monitor
    int         glen = 0;
    logic       prev_en = 1'b0;
    logic [1:0] prev_ch = 2'd0;
    always @(negedge clk) begin
        if (cnt_en && prev_en) chk("ch_sel_stable", 64'(ch_sel), 64'(prev_ch));
        if (cnt_en) begin
            glen++;
        end else if (glen != 0) begin
            if (gate_chk) chk("gate_len", 64'(glen), 64'(cur_g));
            glen = 0;
        end
        prev_en = cnt_en;
        prev_ch = ch_sel;
    end

    function automatic int gate_cycles(input int gs);
        return CLK_FREQ / (10 ** gs);
    endfunction

    // reference: enabled channels visited in order after the last grant
    task automatic model_sweep(input logic [3:0] en, input logic [31:0] val,
                               input int gs);
        longint p;
        int c;
        exp_ch.delete(); exp_f.delete(); exp_o.delete();
        for (int k = 1; k <= 4; k++) begin
            c = (model_last + k) % 4;
            if (en[c]) begin
                p = longint'(val) * longint'(10 ** gs);
                exp_ch.push_back(c);
                if (p > 64'hFFFF_FFFF) begin
                    exp_f.push_back(32'hFFFF_FFFF);
                    exp_o.push_back(1'b1);
                end else begin
                    exp_f.push_back(32'(p));
                    exp_o.push_back(1'b0);
                end
            end
        end
        if (exp_ch.size() > 0) model_last = exp_ch[exp_ch.size()-1];
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_cnt", 64'({cnt_en, cnt_clr, ch_sel}), 64'd0);
        chk("rst_res", 64'({res_ovf, res_ch, res_freq}), 64'd0);
        rst_n = 1'b1;
        model_last = 3;
    endtask

    task automatic collect(input int budget, input bit rnd);
        int cyc, got;
        cyc = 1; got = 0; clr_cyc = -1; v_cyc = -1;
        while (cyc < budget && (got < exp_ch.size() || busy)) begin
            if (cnt_clr && clr_cyc < 0) clr_cyc = cyc;
            if (res_valid && v_cyc < 0) v_cyc = cyc;
            res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (res_valid && res_ready) begin
                if (got < exp_ch.size()) begin
                    chk("res_ch", 64'(res_ch), 64'(exp_ch[got]));
                    chk("res_freq", 64'(res_freq), 64'(exp_f[got]));
                    chk("res_ovf", 64'(res_ovf), 64'(exp_o[got]));
                end else begin
                    chk("extra_result", 64'd1, 64'd0);
                end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("timeout", 64'(cyc >= budget), 64'd0);
        chk("result_count", 64'(got), 64'(exp_ch.size()));
        chk("busy_end", 64'(busy), 64'd0);
        res_ready = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  en;
        logic [1:0]  gs;
        bit          fixed;
        logic [31:0] val;
        int          n;
        logic [7:0]  chs;
        logic [31:0] freq;
        bit          ovf;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int w, got;
        bit seen;

        tbl[0] = '{4'b0001, 2'd0, 1'b0, 32'd1, 1, 8'h00, 32'd1000, 1'b0};
        tbl[1] = '{4'b1010, 2'd1, 1'b1, 32'd7, 2, 8'h0D, 32'd70, 1'b0};
        tbl[2] = '{4'b0100, 2'd3, 1'b1, 32'h0100_0000, 1, 8'h02,
                   32'hFFFF_FFFF, 1'b1};
        tbl[3] = '{4'b1111, 2'd2, 1'b1, 32'd123, 4, 8'b10_01_00_11,
                   32'd12300, 1'b0};
        tbl[4] = '{4'b0000, 2'd0, 1'b1, 32'd5, 0, 8'h00, 32'd0, 1'b0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cont_mode = 1'b0;
        ch_en = 4'd0; gate_sel = 2'd0; res_ready = 1'b1;
        rate = 32'd1; fixed_val = 32'd0; use_fixed = 1'b0;
        gate_chk = 1'b1; cur_g = 0;
        do_reset();

        for (int t = 0; t < 5; t++) begin
            logic [7:0] chs;
            ch_en = tbl[t].en; gate_sel = tbl[t].gs;
            use_fixed = tbl[t].fixed;
            if (tbl[t].fixed) begin
                fixed_val = tbl[t].val; rate = 32'd1;
            end else begin
                rate = tbl[t].val;
            end
            cur_g = gate_cycles(int'(tbl[t].gs));
            exp_ch.delete(); exp_f.delete(); exp_o.delete();
            chs = tbl[t].chs;
            for (int k = 0; k < tbl[t].n; k++) begin
                exp_ch.push_back(int'(chs[2*k +: 2]));
                exp_f.push_back(tbl[t].freq);
                exp_o.push_back(tbl[t].ovf);
            end
            pulse_start();
            collect(cur_g * 5 + 50, 1'b0);
            if (tbl[t].n > 0) begin
                chk("clr_cycle", 64'(clr_cyc), 64'd2);
                chk("valid_cycle", 64'(v_cyc), 64'(4 + cur_g));
                model_last = int'(chs[2*(tbl[t].n-1) +: 2]);
            end
        end

        // random sweeps with random backpressure
        use_fixed = 1'b1;
        for (int r = 0; r < 30; r++) begin
            int gs;
            logic [31:0] val;
            gs = $urandom_range(1, 3);
            val = $urandom >> $urandom_range(0, 31);
            ch_en = 4'($urandom_range(1, 15));
            gate_sel = 2'(gs);
            fixed_val = val;
            cur_g = gate_cycles(gs);
            model_sweep(ch_en, val, gs);
            pulse_start();
            collect(4 * (cur_g + 10) + 400, 1'b1);
        end

        // continuous mode with a 50-cycle stall on the first result
        do_reset();
        cont_mode = 1'b1; ch_en = 4'b1111; gate_sel = 2'd3; cur_g = 1;
        fixed_val = 32'd5; res_ready = 1'b0;
        pulse_start();
        w = 0;
        while (!res_valid && w < 100) begin @(negedge clk); w++; end
        chk("stall_valid_seen", 64'(res_valid), 64'd1);
        for (int i = 0; i < 50; i++) begin
            chk("stall_valid", 64'(res_valid), 64'd1);
            chk("stall_ch", 64'(res_ch), 64'd0);
            chk("stall_freq", 64'(res_freq), 64'd5000);
            chk("stall_no_gate", 64'(cnt_en), 64'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        got = 0; w = 0;
        while (got < 6 && w < 200) begin
            if (res_valid && res_ready) begin
                chk("cont_order", 64'(res_ch), 64'(got % 4));
                chk("cont_freq", 64'(res_freq), 64'd5000);
                got++;
            end
            @(negedge clk); w++;
        end
        chk("cont_count", 64'(got), 64'd6);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("cont_abort_busy", 64'(busy), 64'd0);
        chk("cont_abort_valid", 64'(res_valid), 64'd0);
        chk("cont_abort_cnt_en", 64'(cnt_en), 64'd0);
        cont_mode = 1'b0;

        // abort in gate cycle 40 of channel 2
        do_reset();
        ch_en = 4'b0100; gate_sel = 2'd1; cur_g = 100; gate_chk = 1'b0;
        pulse_start();
        w = 0;
        while (!cnt_en && w < 20) begin @(negedge clk); w++; end
        chk("abort_gate_open", 64'(cnt_en), 64'd1);
        repeat (39) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("abort_cnt_en", 64'(cnt_en), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            seen |= res_valid;
            @(negedge clk);
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        gate_chk = 1'b1;
        model_last = 2;
        ch_en = 4'b1111; gate_sel = 2'd3; cur_g = 1; fixed_val = 32'd11;
        model_sweep(ch_en, fixed_val, 3);
        chk("model_first_ch3", 64'(exp_ch[0]), 64'd3);
        pulse_start();
        collect(200, 1'b0);

        // reset while a result is waiting
        do_reset();
        ch_en = 4'b0001; gate_sel = 2'd3; fixed_val = 32'd9; res_ready = 1'b0;
        pulse_start();
        w = 0;
        while (!res_valid && w < 50) begin @(negedge clk); w++; end
        chk("rst_out_valid_seen", 64'(res_valid), 64'd1);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        chk("rst_out_valid", 64'(res_valid), 64'd0);
        chk("rst_out_freq", 64'(res_freq), 64'd0);
        chk("rst_out_busy", 64'(busy), 64'd0);
        res_ready = 1'b1;
        model_last = 3;
        ch_en = 4'b1111;
        model_sweep(ch_en, fixed_val, 3);
        pulse_start();
        collect(200, 1'b0);

        // start+abort together, and start/gate_sel changes while busy
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'd0);
        ch_en = 4'b0001; gate_sel = 2'd2; cur_g = 10; fixed_val = 32'd3;
        model_sweep(ch_en, fixed_val, 2);
        pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        gate_sel = 2'd0;
        collect(200, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
